// File: rtl/uart_spy_capture.sv
// -----------------------------------------------------------------------------
// uart_spy_capture
//
// N-channel capture engine for UART receive-side write strobes. Each channel
// has a one-entry hold register that stamps the byte with a free-running
// timestamp. A round-robin arbiter merges the holds into one shared show-ahead
// log FIFO. Bytes that arrive while a channel's hold is still occupied (and not
// draining that cycle) are dropped and counted per channel.
//
// Optional feature macro: UART_SPY_MATCH_EN
//   When defined, adds match_en / match_byte inputs and a per-channel
//   saturating match_cnt output that counts captured bytes equal to
//   match_byte, whether or not the byte was dropped.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : asynchronous active-high reset
//   clear      : synchronous flush of holds, FIFO, drop counters, timestamp, rr
//   cap_valid  : per-channel write strobe, one byte per high cycle
//   cap_data   : per-channel byte, channel c at [c*DATA_W +: DATA_W]
//   out_valid  : FIFO non-empty, head record presented
//   out_ready  : consumer accepts the head when out_valid && out_ready
//   out_ch     : head record source channel
//   out_ts     : head record timestamp
//   out_data   : head record byte
//   level      : FIFO occupancy
//   drop_cnt   : per-channel saturating drop counters, 8 bits each
//   match_en   : (UART_SPY_MATCH_EN) enable byte matching
//   match_byte : (UART_SPY_MATCH_EN) byte value to match
//   match_cnt  : (UART_SPY_MATCH_EN) per-channel saturating match counters
// -----------------------------------------------------------------------------
module uart_spy_capture #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        cap_valid,
  input  logic [NUM_CH*DATA_W-1:0] cap_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [TS_W-1:0]          out_ts,
  output logic [DATA_W-1:0]        out_data,
  output logic [LVL_W-1:0]         level,
  output logic [NUM_CH*8-1:0]      drop_cnt
`ifdef UART_SPY_MATCH_EN
  ,
  input  logic                     match_en,
  input  logic [DATA_W-1:0]        match_byte,
  output logic [NUM_CH*8-1:0]      match_cnt
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int REC_W  = CH_W + TS_W + DATA_W;

  // Saturating 8-bit increment used by all per-channel event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

  // (base + offset) mod NUM_CH for offset in [0, NUM_CH]; works for any NUM_CH.
  function automatic logic [CH_W-1:0] ch_wrap_add(input logic [CH_W-1:0] base,
                                                  input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_CH) begin
      sum = sum - NUM_CH;
    end else begin
      sum = sum;
    end
    return sum[CH_W-1:0];
  endfunction

  // Timestamp and arbitration state
  logic [TS_W-1:0]   ts_r;
  logic [CH_W-1:0]   rr_r;

  // Capture holds and drop counters
  logic [NUM_CH-1:0] hold_full_r;
  logic [TS_W-1:0]   hold_ts_r   [NUM_CH];
  logic [DATA_W-1:0] hold_data_r [NUM_CH];
  logic [7:0]        drop_r      [NUM_CH];

  // Log FIFO
  logic [REC_W-1:0]  mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic              out_valid_r;
  logic [CH_W-1:0]   out_ch_r;
  logic [TS_W-1:0]   out_ts_r;
  logic [DATA_W-1:0] out_data_r;

  // Combinational control
  logic              grant_found_s;
  logic [CH_W-1:0]   grant_ch_s;
  logic              pop_s;
  logic              space_s;
  logic              push_s;
  logic [REC_W-1:0]  push_rec_s;
  logic [ADDR_W-1:0] rd_ptr_nxt_s;
  logic [LVL_W-1:0]  level_nxt_s;
  logic [REC_W-1:0]  head_rec_s;

  // Round-robin search: scan from the farthest offset down so the closest
  // full hold at or after rr_r is the one left in grant_ch_s.
  always_comb begin
    grant_found_s = 1'b0;
    grant_ch_s    = {CH_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hold_full_r[ch_wrap_add(rr_r, i)]) begin
        grant_found_s = 1'b1;
        grant_ch_s    = ch_wrap_add(rr_r, i);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // FIFO push/pop decisions and next head record.
  always_comb begin
    pop_s      = out_valid_r && out_ready && !clear;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    space_s    = (level_r != LVL_W'(DEPTH)) || pop_s;
    push_s     = grant_found_s && space_s && !clear;
    push_rec_s = {grant_ch_s, hold_ts_r[grant_ch_s], hold_data_r[grant_ch_s]};
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + ADDR_W'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
    // The next head is the entry being written this cycle only when every
    // older entry has been consumed; otherwise it is already in memory.
    if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_rec_s = push_rec_s;
    end else begin
      head_rec_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Free-running timestamp and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_r <= {TS_W{1'b0}};
      rr_r <= {CH_W{1'b0}};
    end else if (clear) begin
      ts_r <= {TS_W{1'b0}};
      rr_r <= {CH_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_W'(1);
      if (push_s) begin
        rr_r <= ch_wrap_add(grant_ch_s, 1);
      end
    end
  end

  // Per-channel hold registers and drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full_r <= {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        hold_ts_r[c]   <= {TS_W{1'b0}};
        hold_data_r[c] <= {DATA_W{1'b0}};
        drop_r[c]      <= 8'd0;
      end
    end else if (clear) begin
      hold_full_r <= {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        drop_r[c] <= 8'd0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap_valid[c] && (!hold_full_r[c] || (push_s && (grant_ch_s == CH_W'(c))))) begin
          hold_full_r[c] <= 1'b1;
          hold_ts_r[c]   <= ts_r;
          hold_data_r[c] <= cap_data[c*DATA_W +: DATA_W];
        end else if (cap_valid[c]) begin
          drop_r[c] <= sat_inc8(drop_r[c]);
        end else if (push_s && (grant_ch_s == CH_W'(c))) begin
          hold_full_r[c] <= 1'b0;
        end
      end
    end
  end

  // Record storage; contents past the read pointer are never presented.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_rec_s;
    end
  end

  // FIFO pointers, occupancy and registered head record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      out_valid_r <= 1'b0;
      out_ch_r    <= {CH_W{1'b0}};
      out_ts_r    <= {TS_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      level_r     <= level_nxt_s;
      out_valid_r <= (level_nxt_s != {LVL_W{1'b0}});
      // Head fields keep their last value while the FIFO is empty.
      if (level_nxt_s != {LVL_W{1'b0}}) begin
        {out_ch_r, out_ts_r, out_data_r} <= head_rec_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_ch    = out_ch_r;
  assign out_ts    = out_ts_r;
  assign out_data  = out_data_r;
  assign level     = level_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_drop_out
    assign drop_cnt[g*8 +: 8] = drop_r[g];
  end

`ifdef UART_SPY_MATCH_EN
  logic [7:0] match_r [NUM_CH];

  // Per-channel match counters; counted on the strobe, independent of drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        match_r[c] <= 8'd0;
      end
    end else if (clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        match_r[c] <= 8'd0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap_valid[c] && match_en && (cap_data[c*DATA_W +: DATA_W] == match_byte)) begin
          match_r[c] <= sat_inc8(match_r[c]);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_match_out
    assign match_cnt[g*8 +: 8] = match_r[g];
  end
`endif

endmodule
